// File: rtl/mpt_table_responder.sv
// Table-fetch responder for the MPT page-table walker: serves one 64-bit entry read at a
// time from a local word store after a fixed latency, and takes host writes to populate it.
module mpt_table_responder #(
   parameter int                  ADDR_LEN    = 56,
   parameter int                  XLEN        = 64,
   parameter int                  DEPTH_WORDS = 1024,
   parameter logic [ADDR_LEN-1:0] BASE_ADDR   = '0,
   parameter int                  LATENCY     = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           req_i,
   input  logic [ADDR_LEN-1:0]            addr_i,
   output logic                           gnt_o,
   output logic                           rvalid_o,
   output logic [XLEN-1:0]                rdata_o,
   output logic                           err_o,
   output logic                           busy_o,
   input  logic                           cfg_we_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] cfg_idx_i,
   input  logic [XLEN-1:0]                cfg_wdata_i
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [XLEN-1:0]     data_q;
   logic                err_q;
   logic [XLEN-1:0]     store [DEPTH_WORDS];

   logic [ADDR_LEN-1:0] off;
   logic [ADDR_LEN-1:0] idx_full;
   logic                req_err;
   logic [XLEN-1:0]     rd_word;
   logic                gnt;
   logic                accept;
   logic                rvalid;

   // Offset wraps for addresses below the window; the explicit compare catches that case.
   assign off      = addr_i - BASE_ADDR;
   assign idx_full = off >> 3;
   assign req_err  = (addr_i[2:0] != 3'b000) || (addr_i < BASE_ADDR) ||
                     (idx_full >= ADDR_LEN'(DEPTH_WORDS));
   assign rd_word  = store[idx_full[IDX_W-1:0]];

   assign gnt      = (state != WAIT) && !flush_i && !rst_i;
   assign accept   = req_i && gnt;
   assign rvalid   = (state == RESP) && !flush_i && !rst_i;

   assign gnt_o    = gnt;
   assign busy_o   = (state != IDLE);
   assign rvalid_o = rvalid;
   assign rdata_o  = rvalid ? data_q : '0;
   assign err_o    = rvalid ? err_q : 1'b0;

   // Store is intentionally not reset; the read above sees the pre-write value on a same-cycle hit.
   always_ff @(posedge clk_i) begin
      if (cfg_we_i && !rst_i) begin
         store[cfg_idx_i] <= cfg_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (flush_i) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         err_q  <= req_err;
         data_q <= req_err ? '0 : rd_word;
         if (LATENCY == 1) begin
            state <= RESP;
            cnt   <= '0;
         end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
         end
      end else begin
         case (state)
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
